// File: rtl/mem_bus_ctrl.sv
// Memory-stage bus controller: drives SRAM (RAM1) and the memory-mapped UART for loads/stores.
// Latency: load RAM_WAIT+2, SRAM store RAM_WAIT+3, status read 2 cycles (request through DONE).
// Backpressure: memStall holds the pipeline until DONE; optional MEM_BUS_TIMEOUT_EN bounds UART TX waits.
module mem_bus_ctrl #(
    parameter int unsigned RAM_WAIT       = 1,
    parameter logic [15:0] UART_DATA_ADDR = 16'hBF00,
    parameter logic [15:0] UART_STAT_ADDR = 16'hBF01,
    parameter int unsigned TIMEOUT_CYC    = 1023
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] Address,
    input  logic [15:0] WriteData,
    input  logic        MemRead,
    input  logic        MemWrite,
    output logic [15:0] ReadData,
    output logic        memStall,
    output logic [17:0] ram_addr,
    output logic [15:0] ram_dout,
    input  logic [15:0] ram_din,
    output logic        ram_doe,
    output logic        ram_ce_n,
    output logic        ram_oe_n,
    output logic        ram_we_n,
    output logic        uart_rdn,
    output logic        uart_wrn,
    input  logic        uart_dready,
    input  logic        uart_tbre,
    input  logic        uart_tsre,
    output logic        busErr
);

    if (RAM_WAIT < 1 || RAM_WAIT > 15 || TIMEOUT_CYC < 1 || TIMEOUT_CYC > 1023) begin : g_bad_param
        $error("mem_bus_ctrl: RAM_WAIT or TIMEOUT_CYC out of range");
    end

    typedef enum logic [2:0] {
        IDLE, RD, WR_SETUP, WR_PULSE, U_RD, U_WR, U_WAIT, DONE
    } state_t;

    localparam logic [3:0] WAIT_LAST = 4'(RAM_WAIT - 1);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] rdata_q, rdata_d;
    logic        sram_wr_q, sram_wr_d;
    logic        tx_idle;
    logic        wait_last;

    assign tx_idle   = uart_tbre & uart_tsre;
    assign wait_last = (cnt_q == WAIT_LAST);

`ifdef MEM_BUS_TIMEOUT_EN
    localparam logic [9:0] TO_LAST = 10'(TIMEOUT_CYC - 1);
    logic [9:0] to_cnt_q, to_cnt_d;
    logic       bus_err_q, bus_err_d;
`endif

    always_comb begin
        state_d   = state_q;
        rdata_d   = rdata_q;
        sram_wr_d = 1'b0;
`ifdef MEM_BUS_TIMEOUT_EN
        bus_err_d = bus_err_q;
`endif
        case (state_q)
            IDLE: begin
                if (MemWrite) begin
                    if (Address == UART_STAT_ADDR)      state_d = DONE;
                    else if (Address == UART_DATA_ADDR) state_d = U_WR;
                    else                                state_d = WR_SETUP;
                end else if (MemRead) begin
                    if (Address == UART_STAT_ADDR) begin
                        state_d = DONE;
                        rdata_d = {14'b0, uart_dready, tx_idle};
                    end else if (Address == UART_DATA_ADDR) begin
                        state_d = U_RD;
                    end else begin
                        state_d = RD;
                    end
                end
            end
            RD: if (wait_last) begin
                rdata_d = ram_din;
                state_d = DONE;
            end
            WR_SETUP: state_d = WR_PULSE;
            WR_PULSE: if (wait_last) begin
                state_d   = DONE;
                sram_wr_d = 1'b1;
            end
            U_RD: if (wait_last) begin
                rdata_d = {8'h00, ram_din[7:0]};
                state_d = DONE;
            end
            U_WR: if (wait_last) state_d = U_WAIT;
            U_WAIT: begin
                if (tx_idle) begin
                    state_d = DONE;
                end
`ifdef MEM_BUS_TIMEOUT_EN
                else if (to_cnt_q == TO_LAST) begin
                    state_d   = DONE;
                    bus_err_d = 1'b1;
                end
`endif
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Wait counters restart whenever a new state is entered.
        cnt_d = (state_d == state_q) ? cnt_q + 4'd1 : 4'd0;
`ifdef MEM_BUS_TIMEOUT_EN
        to_cnt_d = (state_d == state_q) ? to_cnt_q + 10'd1 : 10'd0;
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            cnt_q     <= 4'd0;
            rdata_q   <= 16'h0000;
            sram_wr_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rdata_q   <= rdata_d;
            sram_wr_q <= sram_wr_d;
        end
    end

`ifdef MEM_BUS_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            to_cnt_q  <= 10'd0;
            bus_err_q <= 1'b0;
        end else begin
            to_cnt_q  <= to_cnt_d;
            bus_err_q <= bus_err_d;
        end
    end
    assign busErr = bus_err_q;
`else
    assign busErr = 1'b0;
`endif

    // DONE after an SRAM store keeps CE and the data driven for address/data hold.
    logic sram_hold;
    assign sram_hold = (state_q == DONE) && sram_wr_q;

    assign ReadData = rdata_q;
    assign ram_addr = {2'b00, Address};
    assign ram_dout = (state_q == U_WR) ? {8'h00, WriteData[7:0]} : WriteData;
    assign ram_doe  = (state_q == WR_SETUP) || (state_q == WR_PULSE) || (state_q == U_WR) || sram_hold;
    assign ram_ce_n = !((state_q == RD) || (state_q == WR_SETUP) || (state_q == WR_PULSE) || sram_hold);
    assign ram_oe_n = (state_q != RD);
    assign ram_we_n = (state_q != WR_PULSE);
    assign uart_rdn = (state_q != U_RD);
    assign uart_wrn = (state_q != U_WR);

    // Gated by reset so an aborted access releases the pipeline immediately.
    assign memStall = rst && ((state_q == IDLE) ? (MemRead || MemWrite) : (state_q != DONE));

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Directed bench for mem_bus_ctrl with a behavioural SRAM/UART model on the shared bus.
module tb_mem_bus_ctrl;
    logic        clk;
    logic        rst;
    logic [15:0] Address, WriteData;
    logic        MemRead, MemWrite;
    logic [15:0] ReadData;
    logic        memStall;
    logic [17:0] ram_addr;
    logic [15:0] ram_dout, ram_din;
    logic        ram_doe, ram_ce_n, ram_oe_n, ram_we_n;
    logic        uart_rdn, uart_wrn;
    logic        uart_dready, uart_tbre, uart_tsre;
    logic        busErr;

    logic [15:0] mem [0:65535];
    logic [15:0] uart_rx;

    int checks = 0;
    int errors = 0;

    // per-access observations
    int          n_stall, n_oe, n_we, n_rdn, n_wrn, n_ce, n_we_bad;
    logic [17:0] addr0;
    logic [15:0] dout_s;
    logic [15:0] d_rdata;
    logic [2:0]  d_strb;   // {ce_n, we_n, doe} in DONE

    mem_bus_ctrl #(
        .RAM_WAIT(1), .UART_DATA_ADDR(16'hBF00), .UART_STAT_ADDR(16'hBF01), .TIMEOUT_CYC(8)
    ) dut (
        .clk(clk), .rst(rst), .Address(Address), .WriteData(WriteData),
        .MemRead(MemRead), .MemWrite(MemWrite), .ReadData(ReadData), .memStall(memStall),
        .ram_addr(ram_addr), .ram_dout(ram_dout), .ram_din(ram_din), .ram_doe(ram_doe),
        .ram_ce_n(ram_ce_n), .ram_oe_n(ram_oe_n), .ram_we_n(ram_we_n),
        .uart_rdn(uart_rdn), .uart_wrn(uart_wrn), .uart_dready(uart_dready),
        .uart_tbre(uart_tbre), .uart_tsre(uart_tsre), .busErr(busErr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    assign ram_din = (!ram_ce_n && !ram_oe_n) ? mem[ram_addr[15:0]] :
                     (!uart_rdn ? uart_rx : 16'h0000);

    always @(negedge clk) begin
        if (!ram_we_n && !ram_ce_n && ram_doe) mem[ram_addr[15:0]] <= ram_dout;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Entered at posedge+1; returns at posedge+1 of the IDLE cycle after DONE.
    task do_access(input logic [15:0] a, input logic [15:0] w, input logic rd, input logic wr,
                   input int tsre_rel);
        int cyc;
        bit run;
        Address = a; WriteData = w; MemRead = rd; MemWrite = wr;
        n_stall = 0; n_oe = 0; n_we = 0; n_rdn = 0; n_wrn = 0; n_ce = 0; n_we_bad = 0;
        addr0 = 18'h0; dout_s = 16'h0;
        cyc = 0;
        run = 1'b1;
        while (run) begin
            if (cyc == tsre_rel) uart_tsre = 1'b1;
            #1;
            if (!memStall || cyc >= 40) begin
                run = 1'b0;
            end else begin
                if (cyc == 0) addr0 = ram_addr;
                n_stall++;
                if (!ram_oe_n) n_oe++;
                if (!ram_we_n) n_we++;
                if (!ram_we_n && (ram_ce_n || !ram_doe)) n_we_bad++;
                if (!uart_rdn) n_rdn++;
                if (!uart_wrn) begin n_wrn++; dout_s = ram_dout; end
                if (!ram_ce_n) n_ce++;
                cyc++;
                @(posedge clk); #1;
            end
        end
        check_val("stall_released", {31'b0, memStall}, 32'd0);
        d_rdata = ReadData;
        d_strb  = {ram_ce_n, ram_we_n, ram_doe};
        @(posedge clk); #1;
        MemRead = 1'b0; MemWrite = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; Address = 16'h0; WriteData = 16'h0; MemRead = 1'b0; MemWrite = 1'b0;
        uart_dready = 1'b0; uart_tbre = 1'b1; uart_tsre = 1'b1; uart_rx = 16'hA5C3;
        mem[16'h4000] = 16'h1234;
        mem[16'h0020] = 16'h5555;
        #3;
        check_val("rst_rdata", ReadData, 32'h0);
        check_val("rst_stall", {31'b0, memStall}, 32'd0);
        check_val("rst_strobes", {26'b0, ram_ce_n, ram_oe_n, ram_we_n, uart_rdn, uart_wrn, ram_doe}, 32'b111110);
        check_val("rst_buserr", {31'b0, busErr}, 32'd0);
        #9 rst = 1'b1;
        @(posedge clk); #1;
        check_val("idle_stall", {31'b0, memStall}, 32'd0);

        // SRAM read
        do_access(16'h4000, 16'h0, 1'b1, 1'b0, -1);
        check_val("rd_stall", n_stall, 2);
        check_val("rd_addr", {14'b0, addr0}, 32'h04000);
        check_val("rd_oe", n_oe, 1);
        check_val("rd_rdata", d_rdata, 32'h1234);

        // SRAM write then read back
        do_access(16'h0010, 16'hBEEF, 1'b0, 1'b1, -1);
        check_val("wr_stall", n_stall, 3);
        check_val("wr_we", n_we, 1);
        check_val("wr_we_bad", n_we_bad, 0);
        check_val("wr_ce", n_ce, 2);
        check_val("wr_done_strb", {29'b0, d_strb}, 32'b011);
        check_val("wr_rdata_hold", d_rdata, 32'h1234);
        do_access(16'h0010, 16'h0, 1'b1, 1'b0, -1);
        check_val("rb_rdata", d_rdata, 32'hBEEF);

        // UART status reads
        uart_dready = 1'b1; uart_tbre = 1'b1; uart_tsre = 1'b0;
        do_access(16'hBF01, 16'h0, 1'b1, 1'b0, -1);
        check_val("st_stall", n_stall, 1);
        check_val("st_rdata", d_rdata, 32'h0002);
        check_val("st_ce", n_ce, 0);
        uart_dready = 1'b0; uart_tsre = 1'b1;
        do_access(16'hBF01, 16'h0, 1'b1, 1'b0, -1);
        check_val("st2_rdata", d_rdata, 32'h0001);

        // UART data read
        do_access(16'hBF00, 16'h0, 1'b1, 1'b0, -1);
        check_val("ur_stall", n_stall, 2);
        check_val("ur_rdn", n_rdn, 1);
        check_val("ur_rdata", d_rdata, 32'h00C3);
        check_val("ur_ce", n_ce, 0);

        // UART write, transmitter busy for five cycles
        uart_tsre = 1'b0;
        do_access(16'hBF00, 16'hAA41, 1'b0, 1'b1, 5);
        check_val("uw_stall", n_stall, 6);
        check_val("uw_wrn", n_wrn, 1);
        check_val("uw_dout", dout_s, 32'h0041);
        check_val("uw_ce", n_ce, 0);
        check_val("uw_rdata_hold", d_rdata, 32'h00C3);
        check_val("uw_buserr", {31'b0, busErr}, 32'd0);

        // Write to status with read also high: write wins and is dropped
        uart_dready = 1'b1;
        do_access(16'hBF01, 16'h1234, 1'b1, 1'b1, -1);
        check_val("sw_stall", n_stall, 1);
        check_val("sw_rdata_hold", d_rdata, 32'h00C3);
        check_val("sw_strobes", n_ce + n_we + n_wrn, 0);

`ifdef MEM_BUS_TIMEOUT_EN
        uart_tsre = 1'b0;
        do_access(16'hBF00, 16'h0055, 1'b0, 1'b1, -1);
        check_val("to_stall", n_stall, 10);
        check_val("to_buserr", {31'b0, busErr}, 32'd1);
        uart_tsre = 1'b1;
        do_access(16'h4000, 16'h0, 1'b1, 1'b0, -1);
        check_val("to_buserr_sticky", {31'b0, busErr}, 32'd1);
`endif

        // Reset during the write pulse
        Address = 16'h0020; WriteData = 16'h1111; MemWrite = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check_val("mr_in_pulse", {31'b0, ram_we_n}, 32'd0);
        rst = 1'b0;
        #1;
        check_val("mr_strobes", {29'b0, ram_we_n, ram_doe, ram_ce_n}, 32'b101);
        check_val("mr_stall", {31'b0, memStall}, 32'd0);
        check_val("mr_rdata", ReadData, 32'h0);
        MemWrite = 1'b0;
        #2 rst = 1'b1;
        @(posedge clk); #1;
        do_access(16'h0020, 16'h0, 1'b1, 1'b0, -1);
        check_val("mr_mem_intact", d_rdata, 32'h5555);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
